// File: rtl/mem_ctl_pkg.sv
// Shared encodings for the data-memory path: load/store type codes, trap causes, access size and FSM states.
// Also holds small decode helpers used by the MEM stage.
package mem_ctl_pkg;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LB  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b100;
  localparam logic [2:0] LD_LBU = 3'b110;

  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;

  localparam logic [1:0] TRAP_NONE     = 2'b00;
  localparam logic [1:0] TRAP_MISALIGN = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  // Unlisted load codes decode by their size bits, so 011/111 are bytes and 101 a half.
  function automatic size_t ld_size(input logic [2:0] ldctr);
    case (ldctr)
      LD_LB, LD_LBU, 3'b011, 3'b111: return SZ_B;
      LD_LH, LD_LHU, 3'b101:         return SZ_H;
      LD_LW:                         return SZ_W;
      default:                       return SZ_W;
    endcase
  endfunction

  function automatic size_t st_size(input logic [1:0] stctr);
    case (stctr)
      ST_SB:   return SZ_B;
      ST_SH:   return SZ_H;
      ST_SW:   return SZ_W;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Single-beat req/ack data-memory bus; the MEM stage is master, the data memory is slave.
interface mem_access_unit_if #(parameter int AW = 32);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mau_lane_align.sv
// Combinational lane steering: store byte-enables/replicated write data, and load extract with sign/zero extend.
// No state, no latency, no backpressure.
module mau_lane_align
  import mem_ctl_pkg::*;
(
  input  size_t       st_sz,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  size_t       ld_sz,
  input  logic        ld_uns,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign ld_b = rdata[{ld_off, 3'b000} +: 8];
  assign ld_h = ld_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_sz)
      SZ_B: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = rdata;
    case (ld_sz)
      SZ_B:    ld_data = ld_uns ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
      SZ_H:    ld_data = ld_uns ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: IDLE->REQ->IDLE, min 2 cycles per op, stalls the pipeline until ack or timeout.
// MAU_MISALIGN_TRAP_EN: misaligned H/W ops trap (cause 01) instead of being force-aligned.
module mem_access_unit
  import mem_ctl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          ex_valid,
  input  logic          ex_is_load,
  input  logic          ex_is_store,
  input  logic [AW-1:0] ex_addr,
  input  logic [31:0]   ex_wdata,
  input  logic [2:0]    ex_ldctr,
  input  logic [1:0]    ex_stctr,
  input  logic [4:0]    ex_rd,
  input  logic [31:0]   ex_pc,
  output logic          stall,
  mem_access_unit_if.master mem,
  output logic          wb_valid,
  output logic [4:0]    wb_rd,
  output logic [31:0]   wb_data,
  output logic          trap,
  output logic [31:0]   trap_pc,
  output logic [1:0]    trap_cause
);

  localparam int TW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  state_t        state;
  logic [TW-1:0] cnt;
  logic          ld_q;
  size_t         ld_sz_q;
  logic          ld_uns_q;
  logic [1:0]    ld_off_q;
  logic [4:0]    rd_q;
  logic [31:0]   pc_q;

  size_t       ex_sz;
  logic [1:0]  ex_off;
  logic        accept;
  logic        mis_trap;
  logic        block_acc;
  logic        timeout_hit;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign ex_sz  = ex_is_load ? ld_size(ex_ldctr) : st_size(ex_stctr);
  assign ex_off = (ex_sz == SZ_W) ? 2'b00 :
                  (ex_sz == SZ_H) ? {ex_addr[1], 1'b0} : ex_addr[1:0];

`ifdef MAU_MISALIGN_TRAP_EN
  assign mis_trap  = ((ex_sz == SZ_H) && ex_addr[0]) || ((ex_sz == SZ_W) && (ex_addr[1:0] != 2'b00));
  // The faulting op is still held in EX/MEM during the trap pulse; don't re-accept it.
  assign block_acc = trap && (trap_cause == TRAP_MISALIGN);
`else
  assign mis_trap  = 1'b0;
  assign block_acc = 1'b0;
`endif

  assign accept      = (state == IDLE) && ex_valid && (ex_is_load || ex_is_store) && !block_acc;
  assign timeout_hit = (TIMEOUT != 0) && (state == REQ) && !mem.mem_ack && (cnt == TW'(TIMEOUT - 1));
  assign stall       = accept || ((state == REQ) && !mem.mem_ack && !timeout_hit);

  mau_lane_align u_align (
    .st_sz    (ex_sz),
    .st_off   (ex_off),
    .st_data  (ex_wdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_sz    (ld_sz_q),
    .ld_uns   (ld_uns_q),
    .ld_off   (ld_off_q),
    .rdata    (mem.mem_rdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= IDLE;
      cnt           <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= 4'b0000;
      mem.mem_wdata <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      trap          <= 1'b0;
      trap_pc       <= '0;
      trap_cause    <= TRAP_NONE;
      ld_q          <= 1'b0;
      ld_sz_q       <= SZ_W;
      ld_uns_q      <= 1'b0;
      ld_off_q      <= 2'b00;
      rd_q          <= '0;
      pc_q          <= '0;
    end else begin
      wb_valid <= 1'b0;
      trap     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (mis_trap) begin
              trap       <= 1'b1;
              trap_cause <= TRAP_MISALIGN;
              trap_pc    <= ex_pc;
            end else begin
              state         <= REQ;
              cnt           <= '0;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= !ex_is_load;
              mem.mem_addr  <= {ex_addr[AW-1:2], 2'b00};
              mem.mem_be    <= ex_is_load ? 4'b1111 : st_be;
              mem.mem_wdata <= ex_is_load ? 32'h0 : st_wdata;
              ld_q          <= ex_is_load;
              ld_sz_q       <= ex_sz;
              ld_uns_q      <= ex_ldctr[2];
              ld_off_q      <= ex_off;
              rd_q          <= ex_rd;
              pc_q          <= ex_pc;
            end
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            state       <= IDLE;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            mem.mem_be  <= 4'b0000;
            if (ld_q) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= ld_data;
            end
          end else if (timeout_hit) begin
            state       <= IDLE;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            mem.mem_be  <= 4'b0000;
            trap        <= 1'b1;
            trap_cause  <= TRAP_TIMEOUT;
            trap_pc     <= pc_q;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: one default-timeout unit for the data paths, one TIMEOUT=4 unit whose memory never acks.
module tb_mem_access_unit;
  import mem_ctl_pkg::*;

  logic        Clk;
  logic        Rst;
  logic        ex_valid, ex_valid_to;
  logic        ex_is_load, ex_is_store;
  logic [31:0] ex_addr, ex_wdata, ex_pc;
  logic [2:0]  ex_ldctr;
  logic [1:0]  ex_stctr;
  logic [4:0]  ex_rd;

  logic        stall, wb_valid, trap;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, trap_pc;
  logic [1:0]  trap_cause;

  logic        to_stall, to_wb_valid, to_trap;
  logic [4:0]  to_wb_rd;
  logic [31:0] to_wb_data, to_trap_pc;
  logic [1:0]  to_trap_cause;

  int n_chk = 0;
  int n_err = 0;

  mem_access_unit_if #(.AW(32)) bus ();
  mem_access_unit_if #(.AW(32)) bus_to ();

  mem_access_unit #(.TIMEOUT(255), .AW(32)) u_dut (
    .Clk(Clk), .Rst(Rst), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_ldctr(ex_ldctr), .ex_stctr(ex_stctr), .ex_rd(ex_rd),
    .ex_pc(ex_pc), .stall(stall), .mem(bus), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .trap(trap), .trap_pc(trap_pc), .trap_cause(trap_cause)
  );

  mem_access_unit #(.TIMEOUT(4), .AW(32)) u_to (
    .Clk(Clk), .Rst(Rst), .ex_valid(ex_valid_to), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_ldctr(ex_ldctr), .ex_stctr(ex_stctr), .ex_rd(ex_rd),
    .ex_pc(ex_pc), .stall(to_stall), .mem(bus_to), .wb_valid(to_wb_valid), .wb_rd(to_wb_rd),
    .wb_data(to_wb_data), .trap(to_trap), .trap_pc(to_trap_pc), .trap_cause(to_trap_cause)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic ld, input logic [2:0] ldc, input logic [1:0] stc,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] pc);
    ex_is_load  = ld;
    ex_is_store = !ld;
    ex_ldctr    = ldc;
    ex_stctr    = stc;
    ex_addr     = a;
    ex_wdata    = wd;
    ex_rd       = rd;
    ex_pc       = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; ex_valid = 1'b0; ex_valid_to = 1'b0;
    set_op(1'b0, LD_LW, ST_SW, 32'h0, 32'h0, 5'd0, 32'h0);
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    bus_to.mem_ack = 1'b0; bus_to.mem_rdata = 32'h0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_be", bus.mem_be, 4'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_trap", trap, 1'b0);
    chk("rst_stall", stall, 1'b0);
    Rst = 1'b0;

    // Ack while idle must be ignored.
    @(negedge Clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_5555;
    @(negedge Clk); bus.mem_ack = 1'b0; #1;
    chk("idle_ack_wb", wb_valid, 1'b0);
    chk("idle_ack_req", bus.mem_req, 1'b0);

    // LB 0x103, ack in first REQ cycle
    @(negedge Clk); set_op(1'b1, LD_LB, ST_SW, 32'h103, 32'h0, 5'd7, 32'h200); ex_valid = 1'b1; #1;
    chk("lb_stall_acc", stall, 1'b1);
    @(negedge Clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80FF_0000; #1;
    chk("lb_req", bus.mem_req, 1'b1);
    chk("lb_addr", bus.mem_addr, 32'h100);
    chk("lb_be", bus.mem_be, 4'hF);
    chk("lb_we", bus.mem_we, 1'b0);
    chk("lb_stall_ack", stall, 1'b0);
    @(negedge Clk); ex_valid = 1'b0; bus.mem_ack = 1'b0; #1;
    chk("lb_wb_valid", wb_valid, 1'b1);
    chk("lb_wb_rd", wb_rd, 5'd7);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_req_drop", bus.mem_req, 1'b0);
    @(negedge Clk); #1;
    chk("lb_wb_pulse", wb_valid, 1'b0);

    // SH 0x22, ack in second REQ cycle
    @(negedge Clk); set_op(1'b0, LD_LW, ST_SH, 32'h22, 32'h1234_ABCD, 5'd0, 32'h204); ex_valid = 1'b1; #1;
    chk("sh_stall_acc", stall, 1'b1);
    @(negedge Clk); #1;
    chk("sh_be", bus.mem_be, 4'b1100);
    chk("sh_wdata", bus.mem_wdata, 32'hABCD_ABCD);
    chk("sh_addr", bus.mem_addr, 32'h20);
    chk("sh_we", bus.mem_we, 1'b1);
    chk("sh_stall_wait", stall, 1'b1);
    @(negedge Clk); bus.mem_ack = 1'b1; #1;
    chk("sh_stall_ack", stall, 1'b0);
    @(negedge Clk); ex_valid = 1'b0; bus.mem_ack = 1'b0; #1;
    chk("sh_no_wb", wb_valid, 1'b0);
    chk("sh_req_drop", bus.mem_req, 1'b0);

    // LHU 0x40, ack after 5 waiting REQ cycles
    @(negedge Clk); set_op(1'b1, LD_LHU, ST_SW, 32'h40, 32'h0, 5'd12, 32'h208); ex_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk); #1;
      chk("lhu_req_hold", bus.mem_req, 1'b1);
      chk("lhu_addr_hold", bus.mem_addr, 32'h40);
      chk("lhu_be_hold", bus.mem_be, 4'hF);
      chk("lhu_stall_hold", stall, 1'b1);
    end
    @(negedge Clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_8001; #1;
    chk("lhu_stall_ack", stall, 1'b0);
    @(negedge Clk); ex_valid = 1'b0; bus.mem_ack = 1'b0; #1;
    chk("lhu_wb_valid", wb_valid, 1'b1);
    chk("lhu_wb_data", wb_data, 32'h0000_8001);
    chk("lhu_no_trap", trap, 1'b0);

    // Timeout unit: LW never acked, TIMEOUT=4
    @(negedge Clk); set_op(1'b1, LD_LW, ST_SW, 32'h10, 32'h0, 5'd4, 32'h300); ex_valid_to = 1'b1; #1;
    chk("to_stall_acc", to_stall, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #1;
      chk("to_req_wait", bus_to.mem_req, 1'b1);
      chk("to_stall_wait", to_stall, 1'b1);
    end
    @(negedge Clk); #1;
    chk("to_req_last", bus_to.mem_req, 1'b1);
    chk("to_stall_release", to_stall, 1'b0);
    @(negedge Clk); ex_valid_to = 1'b0; #1;
    chk("to_trap", to_trap, 1'b1);
    chk("to_cause", to_trap_cause, 2'b10);
    chk("to_pc", to_trap_pc, 32'h300);
    chk("to_req_drop", bus_to.mem_req, 1'b0);
    chk("to_no_wb", to_wb_valid, 1'b0);
    @(negedge Clk); #1;
    chk("to_trap_pulse", to_trap, 1'b0);

    // LW at 0x6
    @(negedge Clk); set_op(1'b1, LD_LW, ST_SW, 32'h6, 32'h0, 5'd9, 32'h400); ex_valid = 1'b1; #1;
    chk("mis_stall", stall, 1'b1);
`ifdef MAU_MISALIGN_TRAP_EN
    @(negedge Clk); #1;
    chk("mis_trap", trap, 1'b1);
    chk("mis_cause", trap_cause, 2'b01);
    chk("mis_pc", trap_pc, 32'h400);
    chk("mis_no_req", bus.mem_req, 1'b0);
    chk("mis_stall_rel", stall, 1'b0);
    @(negedge Clk); ex_valid = 1'b0; #1;
    chk("mis_trap_pulse", trap, 1'b0);
    chk("mis_no_req2", bus.mem_req, 1'b0);
    chk("mis_no_wb", wb_valid, 1'b0);
`else
    @(negedge Clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D; #1;
    chk("al_req", bus.mem_req, 1'b1);
    chk("al_addr", bus.mem_addr, 32'h4);
    chk("al_no_trap", trap, 1'b0);
    @(negedge Clk); ex_valid = 1'b0; bus.mem_ack = 1'b0; #1;
    chk("al_wb_valid", wb_valid, 1'b1);
    chk("al_wb_data", wb_data, 32'hCAFE_F00D);
    chk("al_no_trap2", trap, 1'b0);
`endif

    // Reset during REQ, then a late ack
    @(negedge Clk); set_op(1'b1, LD_LW, ST_SW, 32'h80, 32'h0, 5'd5, 32'h500); ex_valid = 1'b1;
    @(negedge Clk); #1;
    chk("rr_req", bus.mem_req, 1'b1);
    Rst = 1'b1; ex_valid = 1'b0;
    @(negedge Clk); Rst = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_7777; #1;
    chk("rr_req_drop", bus.mem_req, 1'b0);
    chk("rr_stall", stall, 1'b0);
    @(negedge Clk); bus.mem_ack = 1'b0; #1;
    chk("rr_no_wb", wb_valid, 1'b0);

    // Back-to-back SB then LW
    @(negedge Clk); set_op(1'b0, LD_LW, ST_SB, 32'h31, 32'h0000_00A5, 5'd0, 32'h600); ex_valid = 1'b1; #1;
    chk("sb_stall_acc", stall, 1'b1);
    @(negedge Clk); bus.mem_ack = 1'b1; #1;
    chk("sb_be", bus.mem_be, 4'b0010);
    chk("sb_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", bus.mem_addr, 32'h30);
    chk("sb_we", bus.mem_we, 1'b1);
    @(negedge Clk); bus.mem_ack = 1'b0;
    set_op(1'b1, LD_LW, ST_SW, 32'h84, 32'h0, 5'd3, 32'h604); #1;
    chk("b2b_stall_acc", stall, 1'b1);
    chk("b2b_sb_no_wb", wb_valid, 1'b0);
    @(negedge Clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1122_3344; #1;
    chk("lw_req", bus.mem_req, 1'b1);
    chk("lw_addr", bus.mem_addr, 32'h84);
    chk("lw_we", bus.mem_we, 1'b0);
    chk("lw_be", bus.mem_be, 4'hF);
    @(negedge Clk); ex_valid = 1'b0; bus.mem_ack = 1'b0; #1;
    chk("lw_wb_valid", wb_valid, 1'b1);
    chk("lw_wb_rd", wb_rd, 5'd3);
    chk("lw_wb_data", wb_data, 32'h1122_3344);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
